// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the 4x4-scaled display prefetch and host write/read ports.
// Optional macro VRAM_BLANK_ONLY_EN: host grants only during blanking (tear-free updates).
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int FB_W   = 160,
  parameter int FB_H   = 120
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              p_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] colour,
  output logic              video_on
);

  localparam logic [9:0] SCR_W   = 10'(4 * FB_W);
  localparam logic [9:0] SCR_H   = 10'(4 * FB_H);
  localparam logic [9:0] H_LAST  = 10'd796;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic       LAST_RD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    HWR  = 2'd2,
    HRD  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                last_host_reg, last_host_next;
  logic [DATA_W-1:0]   prefetch_reg;
  logic [DATA_W-1:0]   colour_reg;
  logic                video_on_reg;
  logic [DATA_W-1:0]   rd_data_reg;

  logic                ds_tick, in_active, ds;
  logic                fetch_line, fetch_next_row, fetch_wrap;
  logic [9:0]          fetch_row, fetch_col;
  logic [ADDR_W-1:0]   row_ext, disp_addr;
  logic                host_window, wr_ok, rd_ok;

  // Display slot decode: one fetch per 4-pixel column, one column ahead of the beam.
  assign ds_tick        = p_tick && (pixel_x[1:0] == 2'b00);
  assign in_active      = (pixel_x < SCR_W) && (pixel_y < SCR_H);
  assign fetch_line     = (pixel_x < SCR_W - 10'd4) && (pixel_y < SCR_H);
  assign fetch_next_row = (pixel_x == H_LAST) && (pixel_y < SCR_H - 10'd1);
  assign fetch_wrap     = (pixel_x == H_LAST) && (pixel_y == V_LAST);
  assign ds             = ds_tick && (fetch_line || fetch_next_row || fetch_wrap);

  always_comb begin
    fetch_row = '0;
    fetch_col = '0;
    if (fetch_line) begin
      fetch_row = {2'b00, pixel_y[9:2]};
      fetch_col = {2'b00, pixel_x[9:2]} + 10'd1;
    end else if (fetch_next_row) begin
      fetch_row = (pixel_y + 10'd1) >> 2;
    end
  end

  // row*160 as two shifts; the wrap case leaves row and col at zero.
  assign row_ext   = ADDR_W'(fetch_row);
  assign disp_addr = (row_ext << 7) + (row_ext << 5) + ADDR_W'(fetch_col);

`ifdef VRAM_BLANK_ONLY_EN
  assign host_window = !in_active;
`else
  assign host_window = 1'b1;
`endif

  assign wr_ok = wr_req && host_window;
  assign rd_ok = rd_req && host_window && (state_reg != HRD);

  always_comb begin
    state_next     = IDLE;
    last_host_next = last_host_reg;
    if (RESET) begin
      state_next = IDLE;
    end else if (ds) begin
      state_next = DISP;
    end else if (wr_ok && rd_ok) begin
      state_next = (last_host_reg == LAST_RD) ? HWR : HRD;
    end else if (wr_ok) begin
      state_next = HWR;
    end else if (rd_ok) begin
      state_next = HRD;
    end
    if (state_next == HWR || state_next == HRD) begin
      last_host_next = ~last_host_reg;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    case (state_next)
      DISP: mem_addr = disp_addr;
      HWR: begin
        mem_addr  = wr_addr;
        mem_we    = 1'b1;
        mem_wdata = wr_data;
        wr_ack    = 1'b1;
      end
      HRD:     mem_addr = rd_addr;
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      last_host_reg <= LAST_RD;
      prefetch_reg  <= '0;
      colour_reg    <= '0;
      video_on_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      last_host_reg <= last_host_next;
      if (state_reg == DISP) begin
        prefetch_reg <= mem_rdata;
      end
      if (state_reg == HRD) begin
        rd_data_reg <= mem_rdata;
      end
      // Uses the prefetch from the previous slot, so colour holds for a whole column.
      if (ds_tick) begin
        colour_reg   <= in_active ? prefetch_reg : '0;
        video_on_reg <= in_active;
      end
    end
  end

  // Read data arrives one cycle after the grant; present it directly, then hold.
  assign rd_ack   = (state_reg == HRD);
  assign rd_data  = rd_ack ? mem_rdata : rd_data_reg;
  assign colour   = colour_reg;
  assign video_on = video_on_reg;

endmodule
